// File: rtl/hazard_ctrl_if.sv
// Bundle between the 5-stage datapath and the hazard controller.
// master: datapath side (drives hazard inputs, consumes control outputs).
// slave:  hazard_ctrl side.
interface hazard_ctrl_if #(
  parameter int unsigned REG_W = 5
);

  // Hazard inputs from the pipeline
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic [REG_W-1:0] ex_rd;
  logic             ex_mem_read;
  logic             ex_br_taken;
  logic             mem_req;
  logic             mem_ready;

  // Control outputs back to the pipeline
  logic             pc_write;
  logic             fd_stall;
  logic             fd_flush;
  logic             de_bubble;
  logic             pipe_freeze;
  logic             mem_timeout;
  logic [31:0]      stall_cycles;
  logic [31:0]      flush_count;

  modport master (
    output id_rs,
    output id_rt,
    output id_use_rs,
    output id_use_rt,
    output ex_rd,
    output ex_mem_read,
    output ex_br_taken,
    output mem_req,
    output mem_ready,
    input  pc_write,
    input  fd_stall,
    input  fd_flush,
    input  de_bubble,
    input  pipe_freeze,
    input  mem_timeout,
    input  stall_cycles,
    input  flush_count
  );

  modport slave (
    input  id_rs,
    input  id_rt,
    input  id_use_rs,
    input  id_use_rt,
    input  ex_rd,
    input  ex_mem_read,
    input  ex_br_taken,
    input  mem_req,
    input  mem_ready,
    output pc_write,
    output fd_stall,
    output fd_flush,
    output de_bubble,
    output pipe_freeze,
    output mem_timeout,
    output stall_cycles,
    output flush_count
  );

endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/sequencing controller for the 5-stage datapath.
// Handles load-use stalls, taken-branch flushes resolved in EX and multi-cycle
// data-memory waits. Control outputs are a combinational decode of the registered
// FSM state and the current hazard inputs.
// Optional feature: define HAZARD_PERF_EN to build the saturating stall/flush
// performance counters; otherwise both counter outputs are tied to zero.
module hazard_ctrl #(
  parameter int unsigned REG_W       = 5,
  parameter int unsigned MEM_TIMEOUT = 64,  // >= 2
  parameter int unsigned FLUSH_CYC   = 1    // 1..4
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave bus
);

  // Counter widths; wait_cnt must be able to hold MEM_TIMEOUT itself.
  localparam int unsigned WcW = $clog2(MEM_TIMEOUT + 1);
  localparam int unsigned FcW = 3;
  localparam logic [WcW-1:0] WaitMax   = WcW'(MEM_TIMEOUT);
  localparam logic [FcW-1:0] FlushLast = FcW'(FLUSH_CYC - 1);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StFlush   = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [WcW-1:0] wait_cnt_q, wait_cnt_d;
  logic [FcW-1:0] flush_cnt_q, flush_cnt_d;
  logic           timeout_q, timeout_d;

  logic [REG_W-1:0] id_rs, id_rt, ex_rd;
  logic             load_use;
  logic             mem_stall;
  logic [WcW-1:0]   wait_inc;

  logic pc_write, fd_stall, fd_flush, de_bubble, pipe_freeze;

  assign id_rs = bus.id_rs;
  assign id_rt = bus.id_rt;
  assign ex_rd = bus.ex_rd;

  // Register 0 is hard-wired zero, so a load targeting it never creates a hazard.
  assign load_use = bus.ex_mem_read && (ex_rd != '0) &&
                    ((bus.id_use_rs && (id_rs == ex_rd)) ||
                     (bus.id_use_rt && (id_rt == ex_rd)));

  // MEM stage is issuing an access the memory cannot finish this cycle.
  assign mem_stall = bus.mem_req && !bus.mem_ready;

  assign wait_inc = wait_cnt_q + WcW'(1);

  // State register plus wait/flush counters and the sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      wait_cnt_q  <= '0;
      flush_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  // Next-state: memory wait beats branch, branch beats load-use (which needs no state).
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    flush_cnt_d = flush_cnt_q;
    timeout_d   = timeout_q;
    unique case (state_q)
      StRun: begin
        if (mem_stall) begin
          // The entering cycle already counts as the first frozen cycle.
          state_d    = StMemWait;
          wait_cnt_d = WcW'(1);
        end else if (bus.ex_br_taken && (FLUSH_CYC > 1)) begin
          state_d     = StFlush;
          flush_cnt_d = FcW'(1);
        end
      end
      StMemWait: begin
        // EX is frozen here, so branch/load-use are simply re-evaluated back in RUN.
        if (bus.mem_ready) begin
          state_d    = StRun;
          wait_cnt_d = '0;
        end else if (wait_inc == WaitMax) begin
          // Give up on the access and let the frozen stages resume.
          state_d    = StRun;
          wait_cnt_d = '0;
          timeout_d  = 1'b1;
        end else begin
          wait_cnt_d = wait_inc;
        end
      end
      StFlush: begin
        if (mem_stall) begin
          // Remaining flush cycles are abandoned.
          state_d     = StMemWait;
          wait_cnt_d  = WcW'(1);
          flush_cnt_d = '0;
        end else if (bus.ex_br_taken) begin
          flush_cnt_d = FcW'(1);
        end else if (flush_cnt_q == FlushLast) begin
          state_d     = StRun;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q + FcW'(1);
        end
      end
      default: begin
        state_d     = StRun;
        wait_cnt_d  = '0;
        flush_cnt_d = '0;
      end
    endcase
  end

  // Output decode from registered state and current hazard inputs.
  always_comb begin
    pc_write    = 1'b1;
    fd_stall    = 1'b0;
    fd_flush    = 1'b0;
    de_bubble   = 1'b0;
    pipe_freeze = 1'b0;
    if (rst) begin
      // Hold fetch and feed bubbles while the pipeline is being reset.
      pc_write  = 1'b0;
      fd_stall  = 1'b1;
      de_bubble = 1'b1;
    end else begin
      unique case (state_q)
        StRun: begin
          if (mem_stall) begin
            pc_write    = 1'b0;
            fd_stall    = 1'b1;
            pipe_freeze = 1'b1;
          end else if (bus.ex_br_taken) begin
            // Squashes the ID instruction, so a coincident load-use is moot.
            fd_flush  = 1'b1;
            de_bubble = 1'b1;
          end else if (load_use) begin
            pc_write  = 1'b0;
            fd_stall  = 1'b1;
            de_bubble = 1'b1;
          end
        end
        StMemWait: begin
          pc_write    = 1'b0;
          fd_stall    = 1'b1;
          pipe_freeze = 1'b1;
        end
        StFlush: begin
          if (mem_stall) begin
            pc_write    = 1'b0;
            fd_stall    = 1'b1;
            pipe_freeze = 1'b1;
          end else begin
            fd_flush  = 1'b1;
            de_bubble = 1'b1;
          end
        end
        default: begin
          pc_write = 1'b0;
          fd_stall = 1'b1;
        end
      endcase
    end
  end

  assign bus.pc_write    = pc_write;
  assign bus.fd_stall    = fd_stall;
  assign bus.fd_flush    = fd_flush;
  assign bus.de_bubble   = de_bubble;
  assign bus.pipe_freeze = pipe_freeze;
  assign bus.mem_timeout = timeout_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_perf_q;
  logic [31:0] flush_perf_q;
  logic        br_accept;

  // A branch counts only when it is not pre-empted by a memory wait.
  assign br_accept = bus.ex_br_taken && !mem_stall &&
                     ((state_q == StRun) || (state_q == StFlush));

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_perf_q <= '0;
      flush_perf_q <= '0;
    end else begin
      if (fd_stall && (stall_perf_q != '1)) begin
        stall_perf_q <= stall_perf_q + 32'd1;
      end
      if (br_accept && (flush_perf_q != '1)) begin
        flush_perf_q <= flush_perf_q + 32'd1;
      end
    end
  end

  assign bus.stall_cycles = stall_perf_q;
  assign bus.flush_count  = flush_perf_q;
`else
  assign bus.stall_cycles = '0;
  assign bus.flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MEM_TIMEOUT=8, FLUSH_CYC=3).
module tb_hazard_ctrl;

  localparam int unsigned RegW     = 5;
  localparam int unsigned MemTo    = 8;
  localparam int unsigned FlushCyc = 3;

  // {pc_write, fd_stall, fd_flush, de_bubble, pipe_freeze}
  localparam logic [4:0] ONorm   = 5'b10000;
  localparam logic [4:0] OStall  = 5'b01010;
  localparam logic [4:0] OFlush  = 5'b10110;
  localparam logic [4:0] OFreeze = 5'b01001;
  localparam logic [4:0] ORst    = 5'b01010;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned n_checks = 0;
  int unsigned n_errs   = 0;

  hazard_ctrl_if #(.REG_W(RegW)) bus ();

  hazard_ctrl #(
    .REG_W      (RegW),
    .MEM_TIMEOUT(MemTo),
    .FLUSH_CYC  (FlushCyc)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] outs();
    return {bus.pc_write, bus.fd_stall, bus.fd_flush, bus.de_bubble, bus.pipe_freeze};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Let the combinational outputs settle, check them, then advance one clock.
  task automatic step(input string tag, input logic [4:0] exp);
    #1;
    check_eq(tag, 32'(outs()), 32'(exp));
    cyc();
  endtask

  task automatic idle();
    bus.id_rs       = '0;
    bus.id_rt       = '0;
    bus.id_use_rs   = 1'b0;
    bus.id_use_rt   = 1'b0;
    bus.ex_rd       = '0;
    bus.ex_mem_read = 1'b0;
    bus.ex_br_taken = 1'b0;
    bus.mem_req     = 1'b0;
    bus.mem_ready   = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                        input logic urt, input logic [4:0] rd, input logic mr);
    bus.id_rs       = rs;
    bus.id_use_rs   = urs;
    bus.id_rt       = rt;
    bus.id_use_rt   = urt;
    bus.ex_rd       = rd;
    bus.ex_mem_read = mr;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 1'b1;
    cyc();
    cyc();
    #1;
    check_eq("rst_outs", 32'(outs()), 32'(ORst));
    check_eq("rst_timeout", 32'(bus.mem_timeout), 32'd0);
    check_eq("rst_stall_cnt", bus.stall_cycles, 32'd0);
    check_eq("rst_flush_cnt", bus.flush_count, 32'd0);
    rst = 1'b0;
    cyc();

    // Normal flow and load-use stalls
    step("norm", ONorm);
    set_lu(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1);
    step("lu_rs", OStall);
    bus.ex_mem_read = 1'b0;
    step("lu_clear", ONorm);
    set_lu(5'd5, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1);
    step("lu_rt", OStall);
    set_lu(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1);
    step("no_haz_r0", ONorm);
    set_lu(5'd5, 1'b0, 5'd5, 1'b0, 5'd5, 1'b1);
    step("no_haz_nouse", ONorm);
    set_lu(5'd4, 1'b1, 5'd6, 1'b1, 5'd5, 1'b1);
    step("no_haz_diff", ONorm);
    set_lu(5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 1'b0);
    step("no_haz_noload", ONorm);

    // Taken branch with coincident load-use, held FlushCyc cycles
    idle();
    set_lu(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1);
    bus.ex_br_taken = 1'b1;
    step("br_lu", OFlush);
    idle();
    step("flush_c2", OFlush);
    step("flush_c3", OFlush);
    step("flush_done", ONorm);

    // Branch during FLUSH restarts the flush window
    bus.ex_br_taken = 1'b1;
    step("br2", OFlush);
    step("br_restart", OFlush);
    bus.ex_br_taken = 1'b0;
    step("restart_c2", OFlush);
    step("restart_c3", OFlush);
    step("restart_done", ONorm);

    // Memory wait: ready low 4 cycles then high; branch inside the wait is ignored
    bus.mem_req = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.ex_br_taken = (i == 3);
      step($sformatf("mwait_%0d", i), OFreeze);
    end
    bus.ex_br_taken = 1'b0;
    bus.mem_ready   = 1'b1;
    step("mwait_ready", OFreeze);
    idle();
    step("mwait_resume", ONorm);
    check_eq("no_timeout", 32'(bus.mem_timeout), 32'd0);

    // Memory timeout after MemTo frozen cycles
    bus.mem_req = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check_eq($sformatf("to_flag_pre_%0d", i), 32'(bus.mem_timeout), 32'd0);
      step($sformatf("to_freeze_%0d", i), OFreeze);
    end
    idle();
    check_eq("to_flag_set", 32'(bus.mem_timeout), 32'd1);
    step("to_resume", ONorm);
    step("to_idle1", ONorm);
    step("to_idle2", ONorm);
    check_eq("to_flag_sticky", 32'(bus.mem_timeout), 32'd1);

    // Memory wait pre-empts an ongoing flush
    bus.ex_br_taken = 1'b1;
    step("pre_br", OFlush);
    bus.ex_br_taken = 1'b0;
    bus.mem_req     = 1'b1;
    step("pre_freeze1", OFreeze);
    step("pre_freeze2", OFreeze);
    bus.mem_ready = 1'b1;
    step("pre_ready", OFreeze);
    idle();
    step("pre_resume", ONorm);

`ifdef HAZARD_PERF_EN
    // stalls: 2 load-use + 5 mem wait + 8 timeout + 3 pre-empt; branches accepted: 4
    check_eq("perf_stall", bus.stall_cycles, 32'd18);
    check_eq("perf_flush", bus.flush_count, 32'd4);
`else
    check_eq("perf_stall_off", bus.stall_cycles, 32'd0);
    check_eq("perf_flush_off", bus.flush_count, 32'd0);
`endif

    // Reset in the middle of a memory wait
    bus.mem_req = 1'b1;
    step("rmid_freeze", OFreeze);
    rst = 1'b1;
    step("rmid_rst", ORst);
    rst = 1'b0;
    idle();
    step("rmid_run", ONorm);
    check_eq("rmid_timeout", 32'(bus.mem_timeout), 32'd0);
    check_eq("rmid_stall_cnt", bus.stall_cycles, 32'd0);
    check_eq("rmid_flush_cnt", bus.flush_count, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
